// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - single-outstanding word initiator for the on-chip slave bus
//
// Takes one word request at a time from a local requester, runs a single bus
// transfer against the slaves in the address window, and returns a held
// response. Requests outside the window or misaligned are answered with an
// error without touching the bus. A transfer with no bdone within TIMEOUT
// ACCESS cycles is answered with an error.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_addr/write/wdata      request payload (byte address, 4-byte aligned)
//   resp_valid/resp_ready     response handshake
//   resp_rdata/resp_err       response payload, held while resp_valid
//   bus_addr/wdata/ttype      bus transfer payload, zero while bus_ss=0
//   bus_bstart, bus_ss        start strobe (first ACCESS cycle), slave select
//   bus_rdata, bus_bdone      slave read data and completion

module bus_initiator #(
    parameter logic [31:0] SLAVE_BASE = 32'h1000_0000,
    parameter logic [31:0] SLAVE_MASK = 32'hFFFF_F000,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_ttype,
    output logic        bus_bstart,
    output logic        bus_ss,
    input  logic        bus_bdone
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        TT_READ  = 1'b0,
        TT_WRITE = 1'b1
    } ttype_t;

    // Counter holds 0..TIMEOUT, so one bit more than needed for TIMEOUT-1.
    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   addr_q, wdata_q;
    logic          write_q;
    logic [31:0]   rdata_q, rdata_nxt;
    logic          err_q, err_nxt;
    logic          req_ok;

    assign req_ok = ((req_addr & SLAVE_MASK) == SLAVE_BASE) && (req_addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                // Clearing here makes the first ACCESS cycle always see cnt==0.
                cnt_nxt = '0;
                if (req_valid) begin
                    if (req_ok) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end
                end
            end
            ACCESS: begin
                cnt_nxt = cnt + 1'b1;
                // bdone is checked first so it wins on the final timeout cycle.
                if (bus_bdone) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b0;
                    rdata_nxt = write_q ? 32'h0 : bus_rdata;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b0;
                    rdata_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign bus_ss     = (state == ACCESS);
    assign bus_bstart = bus_ss && (cnt == '0);
    assign bus_addr   = bus_ss ? addr_q  : 32'h0;
    assign bus_wdata  = bus_ss ? wdata_q : 32'h0;
    assign bus_ttype  = (bus_ss && write_q) ? TT_WRITE : TT_READ;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - self-checking bench for bus_initiator

module tb_bus_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ttype;
    logic        bus_bstart;
    logic        bus_ss;
    logic        bus_bdone;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_initiator #(
        .SLAVE_BASE(32'h1000_0000),
        .SLAVE_MASK(32'hFFFF_F000),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ttype (bus_ttype),
        .bus_bstart(bus_bstart),
        .bus_ss    (bus_ss),
        .bus_bdone (bus_bdone)
    );

    // Slave model: 16-word register file, write lands on bstart&&ss,
    // bdone after slave_wait extra cycles (negative = never).
    logic [31:0] mem [0:15];
    int          slave_wait;
    int          acc_cnt;

    always_ff @(posedge clk) begin
        if (!bus_ss) acc_cnt <= 0;
        else         acc_cnt <= acc_cnt + 1;
        if (bus_ss && bus_bstart && bus_ttype) mem[bus_addr[5:2]] <= bus_wdata;
    end

    always_comb begin
        bus_rdata = mem[bus_addr[5:2]];
        bus_bdone = bus_ss && (slave_wait >= 0) && (acc_cnt == slave_wait);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [13];

    // Issues one request, waits for the response and checks latency, payload
    // and the bus activity seen on the way.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int bstarts;
        int ss_cycles;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_write  = v.wr;
        req_wdata  = v.wdata;
        slave_wait = v.wt;
        resp_ready = 1'b0;
        chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        bstarts   = 0;
        ss_cycles = 0;
        while (!resp_valid && lat < 40) begin
            if (bus_bstart) bstarts++;
            if (bus_ss) begin
                ss_cycles++;
                chk({tag, ".bus_addr"},  bus_addr,  v.addr);
                chk({tag, ".bus_wdata"}, bus_wdata, v.wdata);
                chk({tag, ".bus_ttype"}, {31'b0, bus_ttype}, {31'b0, v.wr});
            end else begin
                chk({tag, ".idle_addr"}, bus_addr, 32'h0);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"},   lat, v.exp_lat);
        chk({tag, ".resp_err"},  {31'b0, resp_err}, {31'b0, v.exp_err});
        chk({tag, ".resp_rdata"}, resp_rdata, v.exp_rdata);
        chk({tag, ".bstarts"},   bstarts, (v.exp_lat >= 2) ? 1 : 0);
        chk({tag, ".ss_cycles"}, ss_cycles, v.exp_lat - 1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".back_idle"}, {31'b0, req_ready}, 32'd1);
        chk({tag, ".ss_off"},    {31'b0, bus_ss}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h1000_000C, 32'h0000_00A5,  0, 1'b0, 32'h0,          2};
        vecs[1]  = '{1'b0, 32'h1000_000C, 32'h0,          0, 1'b0, 32'h0000_00A5,  2};
        vecs[2]  = '{1'b1, 32'h1000_0020, 32'hDEAD_BEEF,  1, 1'b0, 32'h0,          3};
        vecs[3]  = '{1'b0, 32'h1000_0020, 32'h0,          2, 1'b0, 32'hDEAD_BEEF,  4};
        vecs[4]  = '{1'b0, 32'h2000_0000, 32'h0,          0, 1'b1, 32'h0,          1};
        vecs[5]  = '{1'b0, 32'h1000_0002, 32'h0,          0, 1'b1, 32'h0,          1};
        vecs[6]  = '{1'b1, 32'h1000_1000, 32'h1111_1111,  0, 1'b1, 32'h0,          1};
        vecs[7]  = '{1'b1, 32'h1000_0FFC, 32'h1234_5678,  0, 1'b0, 32'h0,          2};
        vecs[8]  = '{1'b0, 32'h1000_0FFC, 32'h0,          0, 1'b0, 32'h1234_5678,  2};
        vecs[9]  = '{1'b0, 32'h1000_000C, 32'h0,         -1, 1'b1, 32'h0,         17};
        vecs[10] = '{1'b1, 32'h1000_000C, 32'h0000_00A5, -1, 1'b1, 32'h0,         17};
        vecs[11] = '{1'b0, 32'h1000_000C, 32'h0,         15, 1'b0, 32'h0000_00A5, 17};
        vecs[12] = '{1'b0, 32'h0FFF_FFFC, 32'h0,          0, 1'b1, 32'h0,          1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_write  = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        slave_wait = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.req_ready",  {31'b0, req_ready},  32'd1);
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst.resp_err",   {31'b0, resp_err},   32'd0);
        chk("rst.resp_rdata", resp_rdata,          32'h0);
        chk("rst.bus_ss",     {31'b0, bus_ss},     32'd0);
        chk("rst.bus_bstart", {31'b0, bus_bstart}, 32'd0);
        chk("rst.bus_addr",   bus_addr,            32'h0);
        chk("rst.bus_wdata",  bus_wdata,           32'h0);
        chk("rst.bus_ttype",  {31'b0, bus_ttype},  32'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Back-pressure: response held 5 cycles while another request waits.
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 32'h1000_0020;
        req_write  = 1'b0;
        req_wdata  = 32'h0;
        slave_wait = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp.resp_valid0", {31'b0, resp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp.resp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp.resp_rdata", resp_rdata, 32'hDEAD_BEEF);
            chk("bp.resp_err",   {31'b0, resp_err}, 32'd0);
            chk("bp.req_ready",  {31'b0, req_ready}, 32'd0);
            chk("bp.bus_ss",     {31'b0, bus_ss}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req_addr   = 32'h1000_000C;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp.idle_ready",  {31'b0, req_ready}, 32'd1);
        chk("bp.not_taken",   {31'b0, bus_ss}, 32'd0);
        chk("bp.resp_gone",   {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp.taken_ss",     {31'b0, bus_ss}, 32'd1);
        chk("bp.taken_bstart", {31'b0, bus_bstart}, 32'd1);
        @(negedge clk);
        chk("bp.second_resp",  resp_rdata, 32'h0000_00A5);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset during the second ACCESS cycle aborts without a response.
        req_valid  = 1'b1;
        req_addr   = 32'h1000_000C;
        req_write  = 1'b1;
        req_wdata  = 32'h0000_00A5;
        slave_wait = -1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ra.bstart1", {31'b0, bus_bstart}, 32'd1);
        @(negedge clk);
        chk("ra.ss2",     {31'b0, bus_ss}, 32'd1);
        chk("ra.bstart2", {31'b0, bus_bstart}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ra.req_ready",  {31'b0, req_ready},  32'd1);
        chk("ra.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("ra.resp_err",   {31'b0, resp_err},   32'd0);
        chk("ra.resp_rdata", resp_rdata,          32'h0);
        chk("ra.bus_ss",     {31'b0, bus_ss},     32'd0);
        chk("ra.bus_bstart", {31'b0, bus_bstart}, 32'd0);
        chk("ra.bus_addr",   bus_addr,            32'h0);
        chk("ra.bus_wdata",  bus_wdata,           32'h0);
        chk("ra.bus_ttype",  {31'b0, bus_ttype},  32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (resp_valid) seen++;
                @(negedge clk);
            end
            chk("ra.no_resp", seen, 0);
        end
        run_vec(vecs[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Single-outstanding initiator for the on-chip slave bus: it takes word requests from a local requester (core load/store unit or debug port), performs one bus transfer per request against the memory-mapped slaves (gpio and peers), and returns read data or an error. It sits between the requester and the bus fabric. It adds address-window checking, a bdone timeout, and a held response with back-pressure.

## Interface
- SLAVE_BASE, 32'h1000_0000, base of the address window this initiator may access
- SLAVE_MASK, 32'hFFFF_F000, window mask; hit = (req_addr & SLAVE_MASK) == SLAVE_BASE
- TIMEOUT, 16, max cycles in ACCESS waiting for bdone (≥2)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  initiator can accept a request
- req_addr  input  32  byte address, 4-byte aligned
- req_write  input  1  1 = WRITE, 0 = READ
- req_wdata  input  32  write data
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response
- resp_rdata  output  32  read data (0 for writes/errors)
- resp_err  output  1  out-of-window, misaligned, or timeout
- bus_addr  output  32  bus address
- bus_wdata  output  32  bus write data
- bus_rdata  input  32  bus read data
- bus_ttype  output  1  bus transfer type (WRITE/READ enum)
- bus_bstart  output  1  transfer start strobe
- bus_ss  output  1  slave select
- bus_bdone  input  1  slave completion (may be combinational, same cycle)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid at posedge, latch addr/write/wdata.
  - Window hit and addr[1:0]==0 → ACCESS.
  - Otherwise → RESP with resp_err=1, resp_rdata=0. No bus activity.
- ACCESS: bus_ss=1; bus_addr/bus_wdata/bus_ttype driven from latched request, stable the whole state.
  - bus_bstart=1 only in the first ACCESS cycle.
  - Each posedge with bus_bdone=1 → RESP. Capture bus_rdata for reads (0 for writes); resp_err=0.
  - Timeout counter clears on entry and increments per ACCESS cycle. If TIMEOUT cycles elapse without bdone → RESP, resp_err=1, resp_rdata=0.
  - bdone and the final timeout cycle coincide → bdone wins, no error.
- RESP: resp_valid=1; resp_rdata/resp_err held stable. resp_ready at posedge → IDLE.
- req_ready=0 in ACCESS and RESP. Only one request is outstanding.
- When bus_ss=0, the bus outputs are 0: bus_addr, bus_wdata, bus_bstart, and bus_ttype=READ.
- Reset, including mid-ACCESS or mid-RESP:
  - state=IDLE, counter=0.
  - req_ready=1 the cycle after reset deasserts.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - bus_ss=0, bus_bstart=0, bus_addr=0, bus_wdata=0, bus_ttype=READ.
  - The aborted transfer produces no response.

## Timing
- Request accepted at edge N → ACCESS in cycle N+1 with bstart=1.
- Zero-wait slave (bdone=1 in the first cycle): resp_valid in cycle N+2.
- resp_ready high in N+2 → IDLE in N+3. Minimum 3 cycles per transfer.
- Each bdone=0 cycle adds one cycle.
- Timeout: resp_valid TIMEOUT+1 cycles after acceptance.
- Window or alignment error: resp_valid in cycle N+1, no ACCESS cycle.
- Write side effect lands at the slave at the end of the first ACCESS cycle when that slave samples bstart&&ss.

## Test plan
- Write 0x1000_000C ← 0x0000_00A5 to gpio at base 0x1000_0000, then read 0x1000_000C:
  - each transfer shows bstart for 1 cycle;
  - resp_err=0;
  - read returns 0x0000_00A5;
  - the write response arrives 2 cycles after acceptance.
- Read 0x2000_0000 (out of window) and read 0x1000_0002 (misaligned):
  - resp_err=1, resp_rdata=0 in the cycle after acceptance;
  - bus_ss never asserted.
- Slave holding bdone=0 with TIMEOUT=16:
  - ACCESS lasts 16 cycles, then resp_err=1;
  - bus outputs return to 0 and IDLE is reached after resp_ready.
- Slave asserting bdone on the 3rd ACCESS cycle, read returning 0xDEAD_BEEF:
  - bstart only in cycle 1;
  - addr stable all 3 cycles;
  - resp_rdata=0xDEAD_BEEF.
- resp_ready low for 5 cycles:
  - resp_valid/data held;
  - req_ready=0 throughout;
  - a waiting req_valid is not accepted until the cycle after the response handshake.
- rst asserted in the 2nd ACCESS cycle:
  - next cycle all outputs are at reset values and req_ready=1;
  - no resp_valid for the aborted request.
